// File: rtl/mem_bus_controller.sv
// Bus controller between the multicycle core and its synchronous ROM/RAM.
// It arbitrates the fetch and data ports round-robin and holds a small bank of memory-mapped IO registers.
module mem_bus_controller #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 8,
  parameter int                ROM_LATENCY = 1,
  parameter int                RAM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] IO_BASE     = 8'hF0,
  parameter int                NUM_IO      = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic [DATA_W-1:0]        if_rdata,
  output logic                     if_ack,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     d_ack,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic [DATA_W-1:0]        rom_q,
  output logic [ADDR_W-1:0]        ram_address,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  input  logic [DATA_W-1:0]        ram_q,
  input  logic [DATA_W-1:0]        io_in,
  output logic [NUM_IO*DATA_W-1:0] io_out,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROM_RD = 3'd1,
    RAM_RD = 3'd2,
    RAM_WR = 3'd3,
    IO_ACC = 3'd4
  } state_t;

  localparam int LAT_MAX = (ROM_LATENCY > RAM_LATENCY) ? ROM_LATENCY : RAM_LATENCY;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0]  ROM_LAT_C = CNT_W'(ROM_LATENCY);
  localparam logic [CNT_W-1:0]  RAM_LAT_C = CNT_W'(RAM_LATENCY);
  localparam logic [ADDR_W-1:0] NUM_IO_C  = ADDR_W'(NUM_IO);

  state_t              state_r;
  state_t              state_next_s;
  logic                last_grant_r;        // 1 = data port was granted last
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_next_s;
  logic [ADDR_W-1:0]   rom_addr_r;
  logic [ADDR_W-1:0]   d_addr_r;
  logic [DATA_W-1:0]   d_wdata_r;
  logic                d_we_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   if_rdata_next_s;
  logic [DATA_W-1:0]   d_rdata_r;
  logic [DATA_W-1:0]   d_rdata_next_s;
  logic                if_ack_r;
  logic                if_ack_next_s;
  logic                d_ack_r;
  logic                d_ack_next_s;
  logic                ram_wren_r;
  logic                ram_wren_next_s;
  logic [DATA_W-1:0]   io_regs_r [NUM_IO];

  logic                fetch_req_s;
  logic                data_req_s;
  logic                grant_data_s;
  logic                accept_fetch_s;
  logic                accept_data_s;
  logic                d_is_io_s;
  logic                io_wr_s;
  logic [ADDR_W-1:0]   io_idx_s;
  logic [DATA_W-1:0]   io_sel_s;
  logic [DATA_W-1:0]   io_rd_s;

  // A port whose ack is currently high is still holding its old request, so it is masked.
  assign fetch_req_s  = if_req & ~if_ack_r;
  assign data_req_s   = d_req & ~d_ack_r;
  assign grant_data_s = data_req_s & (~fetch_req_s | ~last_grant_r);
  assign d_is_io_s    = (d_addr >= IO_BASE);
  assign io_idx_s     = d_addr_r - IO_BASE;

  assign if_rdata    = if_rdata_r;
  assign d_rdata     = d_rdata_r;
  assign if_ack      = if_ack_r;
  assign d_ack       = d_ack_r;
  assign rom_address = rom_addr_r;
  assign ram_address = d_addr_r;
  assign ram_data    = d_wdata_r;
  assign ram_wren    = ram_wren_r;
  assign busy        = (state_r != IDLE);

  for (genvar k = 0; k < NUM_IO; k++) begin : g_io_out
    assign io_out[k*DATA_W +: DATA_W] = io_regs_r[k];
  end

  // IO read mux: output registers, then the input word, then zero above it.
  always_comb begin
    io_sel_s = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      io_sel_s = io_sel_s | ((io_idx_s == ADDR_W'(k)) ? io_regs_r[k] : {DATA_W{1'b0}});
    end
    if (io_idx_s == NUM_IO_C) begin
      io_rd_s = io_in;
    end else if (io_idx_s < NUM_IO_C) begin
      io_rd_s = io_sel_s;
    end else begin
      io_rd_s = '0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: arbitration and address decode in IDLE, latency countdown elsewhere.
  always_comb begin
    state_next_s   = state_r;
    accept_fetch_s = 1'b0;
    accept_data_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_data_s) begin
          accept_data_s = 1'b1;
          if (d_is_io_s) begin
            state_next_s = IO_ACC;
          end else if (d_we) begin
            state_next_s = RAM_WR;
          end else begin
            state_next_s = RAM_RD;
          end
        end else if (fetch_req_s) begin
          accept_fetch_s = 1'b1;
          state_next_s   = ROM_RD;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROM_RD: begin
        if (cnt_r == ROM_LAT_C) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ROM_RD;
        end
      end
      RAM_RD: begin
        if (cnt_r == RAM_LAT_C) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAM_RD;
        end
      end
      RAM_WR:  state_next_s = IDLE;
      IO_ACC:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered acks, read data, write strobe and wait counter.
  always_comb begin
    if_ack_next_s   = 1'b0;
    d_ack_next_s    = 1'b0;
    ram_wren_next_s = 1'b0;
    io_wr_s         = 1'b0;
    cnt_next_s      = '0;
    if_rdata_next_s = if_rdata_r;
    d_rdata_next_s  = d_rdata_r;
    case (state_r)
      IDLE: begin
        ram_wren_next_s = accept_data_s & ~d_is_io_s & d_we;
      end
      ROM_RD: begin
        if (cnt_r == ROM_LAT_C) begin
          if_ack_next_s   = 1'b1;
          if_rdata_next_s = rom_q;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RAM_RD: begin
        if (cnt_r == RAM_LAT_C) begin
          d_ack_next_s   = 1'b1;
          d_rdata_next_s = ram_q;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RAM_WR: begin
        d_ack_next_s = 1'b1;
      end
      IO_ACC: begin
        d_ack_next_s = 1'b1;
        if (d_we_r) begin
          io_wr_s = 1'b1;
        end else begin
          d_rdata_next_s = io_rd_s;
        end
      end
      default: begin
        d_ack_next_s = 1'b0;
      end
    endcase
  end

  // Datapath registers: request latches, read data, acks, write strobe and IO bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b0;
      cnt_r        <= '0;
      rom_addr_r   <= '0;
      d_addr_r     <= '0;
      d_wdata_r    <= '0;
      d_we_r       <= 1'b0;
      if_rdata_r   <= '0;
      d_rdata_r    <= '0;
      if_ack_r     <= 1'b0;
      d_ack_r      <= 1'b0;
      ram_wren_r   <= 1'b0;
      for (int k = 0; k < NUM_IO; k++) begin
        io_regs_r[k] <= '0;
      end
    end else begin
      cnt_r      <= cnt_next_s;
      if_rdata_r <= if_rdata_next_s;
      d_rdata_r  <= d_rdata_next_s;
      if_ack_r   <= if_ack_next_s;
      d_ack_r    <= d_ack_next_s;
      ram_wren_r <= ram_wren_next_s;
      if (accept_fetch_s) begin
        rom_addr_r   <= if_addr;
        last_grant_r <= 1'b0;
      end
      if (accept_data_s) begin
        d_addr_r     <= d_addr;
        d_wdata_r    <= d_wdata;
        d_we_r       <= d_we;
        last_grant_r <= 1'b1;
      end
      for (int k = 0; k < NUM_IO; k++) begin
        if (io_wr_s && (io_idx_s == ADDR_W'(k))) begin
          io_regs_r[k] <= d_wdata_r;
        end
      end
    end
  end

endmodule
